sfu_accum: RTL and testbench
============================

// Module: sfu_accum
// PURPOSE
//  Special-function/accumulate stage directly downstream of mac_array. It consumes
//  out_s/valid column psums and accumulates them over all kij passes into a
//  DEPTH x COL register file (one 16-bit signed lane per column per output pixel).
//  On command it drains the file, with optional ReLU, into the output SRAM.
//  Lives inside corelet between mac_array and the O_SRAM port.
// PARAMETERS
//  COL      8   number of array columns / lanes per word
//  PSUM_BW  16  signed psum and accumulator lane width
//  DEPTH    16  output pixels per tile, i.e. accumulator entries (power of 2)
//  AW       4   log2(DEPTH), SRAM address width
// PORTS
//  clk         in   1            clock, all state updates on rising edge
//  reset       in   1            synchronous, active-high
//  clear       in   1            zero all entries and lane pointers (new tile)
//  in_psum     in   COL*PSUM_BW  mac_array out_s, lane i = bits [16i+15:16i]
//  in_valid    in   COL          mac_array valid, per lane
//  drain_start in   1            1-cycle pulse: begin write-out to O_SRAM
//  relu_en     in   1            sampled with drain_start: clamp negatives to 0
//  O_D         out  COL*PSUM_BW  SRAM write data
//  O_ADDR      out  AW           SRAM address
//  O_CEN       out  1            SRAM chip enable, active-low
//  O_WEN       out  1            SRAM write enable, active-low
//  busy        out  1            high while draining
//  drain_done  out  1            1-cycle pulse after last write
//  err_drop    out  1            sticky: valid lane arrived during DRAIN
// BEHAVIOUR
//  Reset: all entries 0, all pointers 0, state ACC, O_D=0, O_ADDR=0, O_CEN=1,
//   O_WEN=1, busy=0, drain_done=0, err_drop=0. Reset wins over every other input.
//  All outputs are registered. No combinational paths from inputs to outputs.
//  Accumulate (state ACC): for each lane i with in_valid[i]=1:
//   acc[ptr[i]][i] <= acc[ptr[i]][i] + in_psum lane i. The add is signed, PSUM_BW
//   bits, and wraps in two's complement (no saturation). Then ptr[i] <= ptr[i]+1.
//   The pointer wraps DEPTH-1 -> 0, so each kij pass adds into the same 16 entries.
//  Lanes are fully independent: each lane's valid and pointer act alone, so skewed
//   column timing from the array is tolerated. An update is visible in the
//   register file one cycle later.
//  clear (any state): next cycle all entries and pointers are 0 and err_drop is 0.
//   If clear arrives during DRAIN, the drain aborts: the state goes to ACC,
//   O_CEN=O_WEN=1, busy=0, and no drain_done is issued.
//   clear and in_valid in the same cycle: clear wins and the psum is discarded.
//  FSM has three states: ACC, DRAIN, DONE.
//   ACC   --drain_start & !clear--> DRAIN. At this edge cnt<=0 and relu_r<=relu_en.
//   DRAIN: each cycle drives O_CEN=0, O_WEN=0, O_ADDR=cnt, and
//     O_D=relu_r ? max(acc[cnt],0) per lane : acc[cnt]. Then cnt<=cnt+1.
//     After cnt=DEPTH-1 the state goes to DONE.
//   DONE: O_CEN=O_WEN=1, drain_done=1 for one cycle, then -> ACC.
//   drain_start during DRAIN or DONE is ignored.
//  Drain timing: drain_start at edge T gives writes on cycles T+1..T+DEPTH
//   (addresses 0..DEPTH-1), busy=1 on those same cycles, and drain_done=1 at
//   T+DEPTH+1.
//  Drain does not modify the accumulators; the file holds its contents until clear.
//  in_valid lanes during DRAIN or DONE: the psum is dropped, the pointer is not
//   advanced, and err_drop is set to 1 (sticky until clear or reset).
//  Outside DRAIN: O_CEN=O_WEN=1 and O_D/O_ADDR hold their last values.
//  Read-during-accumulate never happens, because DRAIN blocks accumulation.
// TESTING
//  1 reset, then idle 5 cycles -> O_CEN=O_WEN=1, O_D=0, busy=0, err_drop=0.
//  2 clear; 16 cycles in_valid=8'hFF, all lanes psum=3; repeat 9 passes; drain,
//    relu_en=0 -> 16 writes, addr 0..15, every lane=27, drain_done at T+17.
//  3 lane0 psum=-5 only (others 0) at entry 0, drain relu_en=1 -> addr0 lane0=0;
//    same with relu_en=0 -> lane0=16'hFFFB.
//  4 skew: lane i valid starts i cycles late, 16 values each = pixel index ->
//    entry k holds k in every lane; 17th valid on lane 0 wraps and adds to entry 0.
//  5 lane overflow: 16'h7FFF + 1 -> 16'h8000 (wrap); clear together with valid ->
//    entry stays 0 and pointer 0.
//  6 clear at drain cycle 5 -> O_CEN=1 next cycle, no drain_done, all entries 0;
//    valid during drain -> err_drop=1 and the pointer is unchanged.

Source files
------------

// File: rtl/sfu_accum.sv
// Accumulate stage behind mac_array: sums per-lane column psums into a DEPTH x COL
// register file across kij passes, then drains it (optionally ReLU'd) to the output SRAM.
module sfu_accum #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [COL*PSUM_BW-1:0] in_psum,
  input  logic [COL-1:0]         in_valid,
  input  logic                   drain_start,
  input  logic                   relu_en,
  output logic [COL*PSUM_BW-1:0] O_D,
  output logic [AW-1:0]          O_ADDR,
  output logic                   O_CEN,
  output logic                   O_WEN,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   err_drop
);

  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic                      relu_q, relu_d;
  logic [COL*PSUM_BW-1:0]    o_d_q, o_d_d;
  logic [AW-1:0]             o_addr_q, o_addr_d;
  logic                      o_cen_q, o_cen_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q;

  logic signed [PSUM_BW-1:0] acc_q [DEPTH][COL];
  logic [AW-1:0]             ptr_q [COL];
  logic signed [PSUM_BW-1:0] lane  [COL];
  logic [COL*PSUM_BW-1:0]    drain_word;

  function automatic logic signed [PSUM_BW-1:0] relu_f(
    input logic signed [PSUM_BW-1:0] x,
    input logic                      en
  );
    return (en && x[PSUM_BW-1]) ? '0 : x;
  endfunction

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      lane[i] = $signed(in_psum[i*PSUM_BW +: PSUM_BW]);
    end
  end

  always_comb begin
    drain_word = '0;
    for (int i = 0; i < COL; i++) begin
      drain_word[i*PSUM_BW +: PSUM_BW] = relu_f(acc_q[cnt_q][i], relu_q);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relu_d   = relu_q;
    o_d_d    = o_d_q;
    o_addr_d = o_addr_q;
    o_cen_d  = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ACC: begin
        if (drain_start) begin
          state_d = DRAIN;
          cnt_d   = '0;
          relu_d  = relu_en;
        end
      end
      DRAIN: begin
        o_cen_d  = 1'b0;
        busy_d   = 1'b1;
        o_addr_d = cnt_q;
        o_d_d    = drain_word;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
    // A clear aborts any drain in flight; the partial write is suppressed.
    if (clear) begin
      state_d  = ACC;
      o_d_d    = o_d_q;
      o_addr_d = o_addr_q;
      o_cen_d  = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      relu_q   <= 1'b0;
      o_d_q    <= '0;
      o_addr_q <= '0;
      o_cen_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relu_q   <= relu_d;
      o_d_q    <= o_d_d;
      o_addr_q <= o_addr_d;
      o_cen_q  <= o_cen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Per-lane accumulate; lanes own their pointers so skewed columns line up per pixel
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int i = 0; i < COL; i++) begin
          acc_q[e][i] <= '0;
        end
      end
      for (int i = 0; i < COL; i++) begin
        ptr_q[i] <= '0;
      end
    end else if (state_q == ACC) begin
      for (int i = 0; i < COL; i++) begin
        if (in_valid[i]) begin
          acc_q[ptr_q[i]][i] <= acc_q[ptr_q[i]][i] + lane[i];
          ptr_q[i]           <= ptr_q[i] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_q <= 1'b0;
    end else if (state_q != ACC && |in_valid) begin
      err_q <= 1'b1;
    end
  end

  assign O_D        = o_d_q;
  assign O_ADDR     = o_addr_q;
  assign O_CEN      = o_cen_q;
  assign O_WEN      = o_cen_q;
  assign busy       = busy_q;
  assign drain_done = done_q;
  assign err_drop   = err_q;

endmodule

// File: tb/tb_sfu_accum.sv
// Directed bench for sfu_accum: a vector table for single-entry arithmetic/ReLU cases
// plus hand-written sequences for multi-pass accumulation, skew, drop and abort.
module tb_sfu_accum;
  localparam int COL = 8, PW = 16, DEPTH = 16, AW = 4;

  logic               clk = 1'b0;
  logic               reset, clear, drain_start, relu_en;
  logic [COL*PW-1:0]  in_psum;
  logic [COL-1:0]     in_valid;
  logic [COL*PW-1:0]  O_D;
  logic [AW-1:0]      O_ADDR;
  logic               O_CEN, O_WEN, busy, drain_done, err_drop;

  int checks = 0;
  int errors = 0;
  logic [COL*PW-1:0] cap [DEPTH];
  logic [COL*PW-1:0] exp_w;

  typedef struct {
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic          relu;
    logic [PW-1:0] exp;
  } vec_t;
  vec_t vt [6];

  sfu_accum #(.COL(COL), .PSUM_BW(PW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_psum(in_psum), .in_valid(in_valid),
    .drain_start(drain_start), .relu_en(relu_en), .O_D(O_D), .O_ADDR(O_ADDR),
    .O_CEN(O_CEN), .O_WEN(O_WEN), .busy(busy), .drain_done(drain_done), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [COL-1:0] v, input logic [COL*PW-1:0] p);
    in_valid = v;
    in_psum  = p;
    tick();
    in_valid = '0;
    in_psum  = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Full drain; optionally injects a valid beat on the second write cycle.
  task automatic do_drain(input logic relu, input logic [COL-1:0] inj);
    int bad;
    bad = 0;
    drain_start = 1'b1;
    relu_en     = relu;
    tick();
    drain_start = 1'b0;
    relu_en     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      in_valid = '0;
      in_psum  = '0;
      cap[k] = O_D;
      if (O_CEN !== 1'b0 || O_WEN !== 1'b0 || busy !== 1'b1 ||
          O_ADDR !== AW'(k) || drain_done !== 1'b0) bad++;
      if (k == 0 && inj != '0) begin
        in_valid = inj;
        in_psum  = {COL{16'd50}};
      end
    end
    chk("drain_write_cycles", 128'(bad), 128'd0);
    tick();
    chk("drain_done_pulse", {drain_done, O_CEN, O_WEN, busy}, 4'b1110);
    tick();
    chk("drain_done_low", {drain_done, O_CEN, busy}, 3'b010);
  endtask

  initial begin
    vt[0] = '{a: 16'hFFFB, b: 16'h0000, relu: 1'b1, exp: 16'h0000};
    vt[1] = '{a: 16'hFFFB, b: 16'h0000, relu: 1'b0, exp: 16'hFFFB};
    vt[2] = '{a: 16'h7FFF, b: 16'h0001, relu: 1'b0, exp: 16'h8000};
    vt[3] = '{a: 16'h7FFF, b: 16'h0001, relu: 1'b1, exp: 16'h0000};
    vt[4] = '{a: 16'h0100, b: 16'hFFFF, relu: 1'b1, exp: 16'h00FF};
    vt[5] = '{a: 16'h0003, b: 16'h0004, relu: 1'b1, exp: 16'h0007};

    reset = 1'b1; clear = 1'b0; drain_start = 1'b0; relu_en = 1'b0;
    in_valid = '0; in_psum = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_cen_wen", {O_CEN, O_WEN}, 2'b11);
    chk("rst_od", O_D, '0);
    chk("rst_addr", 128'(O_ADDR), 128'd0);
    chk("rst_flags", {busy, drain_done, err_drop}, 3'b000);

    // Nine full passes of psum 3 on every lane
    pulse_clear();
    for (int p = 0; p < 9; p++)
      for (int k = 0; k < DEPTH; k++) push(8'hFF, {COL{16'd3}});
    do_drain(1'b0, '0);
    for (int k = 0; k < DEPTH; k++) chk($sformatf("pass9_e%0d", k), cap[k], {COL{16'd27}});
    chk("od_holds", O_D, {COL{16'd27}});
    chk("no_err_drop", 128'(err_drop), 128'd0);
    do_drain(1'b1, '0);
    chk("redrain_e7", cap[7], {COL{16'd27}});

    // Single-entry arithmetic / ReLU vectors on lane 0
    foreach (vt[r]) begin
      pulse_clear();
      push(8'h01, {112'b0, vt[r].a});
      repeat (15) push(8'h01, '0);
      push(8'h01, {112'b0, vt[r].b});
      do_drain(vt[r].relu, '0);
      chk($sformatf("tbl%0d_lane0", r), 128'(cap[0][15:0]), 128'(vt[r].exp));
      chk($sformatf("tbl%0d_rest", r), {cap[0][127:16], cap[1]}, '0);
    end

    // Skewed lanes: lane i starts i cycles late; lane 0 gets a 17th beat of 100
    pulse_clear();
    for (int t = 0; t < 23; t++) begin
      in_valid = '0;
      in_psum  = '0;
      for (int i = 0; i < COL; i++) begin
        if (t >= i && t - i < DEPTH) begin
          in_valid[i] = 1'b1;
          in_psum[i*PW +: PW] = 16'(t - i);
        end
      end
      if (t == 16) begin
        in_valid[0]   = 1'b1;
        in_psum[15:0] = 16'd100;
      end
      tick();
    end
    in_valid = '0; in_psum = '0;
    do_drain(1'b0, '0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_w = {COL{16'(k)}};
      if (k == 0) exp_w[15:0] = 16'd100;
      chk($sformatf("skew_e%0d", k), cap[k], exp_w);
    end

    // clear together with valid: beat discarded, pointers stay at 0
    pulse_clear();
    clear = 1'b1;
    push(8'hFF, {COL{16'd5}});
    clear = 1'b0;
    push(8'hFF, {COL{16'd1}});
    do_drain(1'b0, '0);
    chk("clr_valid_e0", cap[0], {COL{16'd1}});
    chk("clr_valid_e1", cap[1], '0);

    // Valid during drain is dropped without moving the pointer
    pulse_clear();
    repeat (3) push(8'h01, {112'b0, 16'd1});
    do_drain(1'b0, 8'h01);
    chk("err_drop_sticky", 128'(err_drop), 128'd1);
    push(8'h01, {112'b0, 16'd7});
    do_drain(1'b0, '0);
    chk("drop_ptr_e3", 128'(cap[3][15:0]), 128'd7);
    chk("drop_ptr_e4", 128'(cap[4][15:0]), 128'd0);

    // clear at drain cycle 5 aborts the drain
    pulse_clear();
    repeat (DEPTH) push(8'hFF, {COL{16'd2}});
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    tick();
    push(8'h02, {COL{16'd9}});
    chk("drain_err_set", {err_drop, O_CEN}, 2'b10);
    repeat (3) tick();
    chk("abort_at_addr", 128'(O_ADDR), 128'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_outputs", {O_CEN, O_WEN, busy, err_drop}, 4'b1100);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        if (drain_done !== 1'b0 || O_CEN !== 1'b1) seen++;
        tick();
      end
      chk("abort_no_done", 128'(seen), 128'd0);
    end
    do_drain(1'b0, '0);
    begin
      int nz;
      nz = 0;
      for (int k = 0; k < DEPTH; k++) if (cap[k] !== '0) nz++;
      chk("abort_cleared", 128'(nz), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
